// File: rtl/serial_comparator_pkg.sv
// Shared definitions for the serial comparator and future multi-cycle ALU helpers:
// FSM state encodings and the WIDTH/DIGIT legality check.
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StDone = 2'd2
   } state_e;

   // True when width splits into a whole number of digit-sized slices.
   function automatic bit cfg_ok(input int unsigned width, input int unsigned digit);
      return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice pair.
module digit_compare
   import serial_comparator_pkg::*;
#(
   parameter int unsigned DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             ltu,
   output logic             eq
);

   assign ltu = (a < b);
   assign eq  = (a == b);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first one DIGIT slice per cycle
// and reports signed-less-than, unsigned-less-than and equality together.
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DIGIT      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             ltu,
   output logic             eq
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
      $error("serial_comparator: WIDTH must be a multiple of DIGIT and DIGIT in 1..WIDTH");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             found_q, found_d;
   // Unsigned verdict of the first differing slice, held while the rest is scanned.
   logic             dltu_q, dltu_d;
   logic             lt_q, lt_d, ltu_q, ltu_d, eq_q, eq_d;

   logic [WIDTH-1:0] a_sh, b_sh;
   logic [DIGIT-1:0] a_slice, b_slice;
   logic             slice_ltu, slice_eq;
   logic             new_found, new_ltu, finish;

   assign a_sh    = a_q >> (32'(idx_q) * DIGIT);
   assign b_sh    = b_q >> (32'(idx_q) * DIGIT);
   assign a_slice = a_sh[DIGIT-1:0];
   assign b_slice = b_sh[DIGIT-1:0];

   digit_compare #(
      .DIGIT (DIGIT)
   ) u_digit_compare (
      .a   (a_slice),
      .b   (b_slice),
      .ltu (slice_ltu),
      .eq  (slice_eq)
   );

   // Next-state logic: accept in IDLE, walk slices in SCAN, hold the result in DONE.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      found_d   = found_q;
      dltu_d    = dltu_q;
      lt_d      = lt_q;
      ltu_d     = ltu_q;
      eq_d      = eq_q;
      new_found = found_q | ~slice_eq;
      new_ltu   = found_q ? dltu_q : slice_ltu;
      finish    = (idx_q == '0) || (EARLY_EXIT && !slice_eq);
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               idx_d   = IW'(NDIG - 1);
               found_d = 1'b0;
               state_d = StScan;
            end
         end
         StScan: begin
            found_d = new_found;
            dltu_d  = new_ltu;
            if (finish) begin
               eq_d  = ~new_found;
               ltu_d = new_found & new_ltu;
               if (!new_found) begin
                  lt_d = 1'b0;
               end else if (a_q[WIDTH-1] != b_q[WIDTH-1]) begin
                  lt_d = a_q[WIDTH-1];
               end else begin
                  lt_d = new_ltu;
               end
               state_d = StDone;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         found_q <= 1'b0;
         dltu_q  <= 1'b0;
         lt_q    <= 1'b0;
         ltu_q   <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         found_q <= found_d;
         dltu_q  <= dltu_d;
         lt_q    <= lt_d;
         ltu_q   <= ltu_d;
         eq_q    <= eq_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign lt        = lt_q;
   assign ltu       = ltu_q;
   assign eq        = eq_q;

endmodule
